systolic_mac_ctrl: RTL
======================

Name: systolic_mac_ctrl

Overview:
Sequencing controller for the systolic MAC array. It accepts a job of k_len operand beats from upstream and clears the accumulators. It feeds the beats into the array, then flushes the skewed wavefront using an external controlled_counter through the cnt_en/cnt_done pair. Finally it drains ARRAY_DIM result rows downstream over a valid/ready handshake and pulses done.

Parameters:
ARRAY_DIM, 4, array rows/cols; number of result rows drained; flush length is 2*ARRAY_DIM-2.
K_WIDTH, 8, width of k_len and the internal beat counter; max job length 2^K_WIDTH-1.
ROW_WIDTH, 2, width of out_row; must satisfy 2^ROW_WIDTH >= ARRAY_DIM.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  job request; sampled in IDLE only.
k_len  input  K_WIDTH  inner-dimension beat count; latched when start is accepted.
busy  output  1  high in every state except IDLE.
done  output  1  single-cycle job-complete pulse.
in_valid  input  1  upstream operand beat valid.
in_ready  output  1  controller accepts a beat; high only in FEED.
acc_clr  output  1  accumulator clear to the array; one cycle.
mac_en  output  1  array advance/compute enable.
cnt_en  output  1  enable to the flush counter, a controlled_counter with count_limit = 2*ARRAY_DIM-2.
cnt_done  input  1  registered done pulse from the flush counter.
out_valid  output  1  result row valid to downstream.
out_ready  input  1  downstream accepts the row.
out_row  output  ROW_WIDTH  index of the row presented, 0..ARRAY_DIM-1.

Behaviour:
- Reset: async, active-high.
  - State goes to IDLE; beat counter, row index and latched k_len all go to 0.
  - All outputs read 0: busy, done, in_ready, acc_clr, mac_en, cnt_en, out_valid, out_row.
  - Reset mid-job aborts the job with no done pulse. The shared rst clears the flush counter.
- States: IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE. Outputs decode from the registered state, except where noted.
- IDLE:
  - start=1 with k_len!=0: latch k_len, go to CLEAR.
  - start=1 with k_len==0: go directly to DONE; no acc_clr, mac_en or cnt_en.
- CLEAR: acc_clr=1 for exactly one cycle, then FEED.
- FEED:
  - in_ready=1.
  - mac_en = in_valid (combinational). A beat is transferred when in_valid && in_ready.
  - Each transferred beat increments the beat counter.
  - On the beat that makes count == latched k_len, go to FLUSH.
  - in_valid low stalls FEED with no mac_en; there is no timeout.
- FLUSH:
  - cnt_en = !cnt_done (combinational) and mac_en = cnt_en. This zero-pads the wavefront for L = 2*ARRAY_DIM-2 cycles.
  - cnt_done rises one cycle after the L-th enabled cycle. On that cycle cnt_en=0, so the counter stays at 0 for the next job; go to DRAIN.
  - FLUSH therefore lasts L+1 cycles.
  - cnt_done in any other state is ignored.
- DRAIN:
  - out_valid=1 and out_row holds the current row index.
  - Advance the row on out_valid && out_ready.
  - While out_ready=0, out_valid and out_row stay stable.
  - Acceptance of row ARRAY_DIM-1 goes to DONE.
- DONE: done=1 and busy=1 for one cycle, then IDLE.
  - A start in this cycle is ignored; a new start is accepted the following cycle.
- start while busy is ignored, and k_len changes after the latch have no effect.
- Beat counter is K_WIDTH bits and never wraps, because the exit compare occurs at k_len <= 2^K_WIDTH-1.
- Latency, with continuous in_valid/out_ready and start sampled at edge 0:
  - CLEAR at cycle 1, FEED at 2..k_len+1, FLUSH for L+1 cycles, DRAIN for ARRAY_DIM cycles.
  - done at cycle k_len + L + ARRAY_DIM + 3.

Test Plan:
1. ARRAY_DIM=4, k_len=3, in_valid=1, out_ready=1. Expect:
   - acc_clr at cycle 1; mac_en at cycles 2-4 and 5-10 (9 total); cnt_done at 11.
   - out_row 0,1,2,3 at cycles 12-15; done at cycle 16; counter count=0 afterwards.
2. k_len=2, in_valid pattern 1,0,0,1 in FEED -> exactly 2 mac_en pulses in FEED; FEED lasts 4 cycles; done delayed by 2 versus a bubble-free job.
3. k_len=1, out_ready=0 for the first 5 DRAIN cycles -> out_valid stays 1 and out_row stays 0 throughout; done arrives 5 cycles later than the no-stall case.
4. start with k_len=0 -> DONE the next cycle, done=1 for one cycle; acc_clr, mac_en, cnt_en, in_ready and out_valid never assert.
5. rst pulsed during FLUSH cycle 3 (ARRAY_DIM=4, k_len=3) -> all outputs 0 immediately, no done; a new start with k_len=3 then reproduces the scenario-1 timing exactly.
6. start re-asserted with k_len=7 during FEED and during DONE -> ignored; the job completes with the original k_len (3 beats); the next start in IDLE is accepted.

Source files
------------

// File: rtl/systolic_mac_ctrl.sv
// Sequencing controller for the systolic MAC array.
// A job of k_len operand beats is cleared, fed, flushed through an external
// flush counter (cnt_en/cnt_done), and then its ARRAY_DIM result rows are
// drained over a valid/ready handshake, ending in a one-cycle done pulse.
module systolic_mac_ctrl #(
    parameter int unsigned ARRAY_DIM = 4,
    parameter int unsigned K_WIDTH   = 8,
    parameter int unsigned ROW_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [K_WIDTH-1:0]   k_len,
    output logic                 busy,
    output logic                 done,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 acc_clr,
    output logic                 mac_en,
    output logic                 cnt_en,
    input  logic                 cnt_done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ROW_WIDTH-1:0] out_row
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [ROW_WIDTH-1:0] LAST_ROW = ROW_WIDTH'(ARRAY_DIM - 1);

    state_e               state_q, state_d;
    logic [K_WIDTH-1:0]   beat_q, beat_d;
    logic [K_WIDTH-1:0]   klen_q, klen_d;
    logic [ROW_WIDTH-1:0] row_q, row_d;
    logic [K_WIDTH-1:0]   beat_inc;

    // State, beat counter, latched job length and drain row index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            klen_q  <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            klen_q  <= klen_d;
            row_q   <= row_d;
        end
    end

    // Next-state logic and output decode from the registered state.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        klen_d    = klen_q;
        row_d     = row_q;
        beat_inc  = beat_q + 1'b1;
        busy      = (state_q != S_IDLE);
        done      = 1'b0;
        in_ready  = 1'b0;
        acc_clr   = 1'b0;
        mac_en    = 1'b0;
        cnt_en    = 1'b0;
        out_valid = 1'b0;
        out_row   = row_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (k_len != '0) begin
                        klen_d  = k_len;
                        beat_d  = '0;
                        state_d = S_CLEAR;
                    end else begin
                        // Empty job skips straight to completion.
                        state_d = S_DONE;
                    end
                end
            end
            S_CLEAR: begin
                acc_clr = 1'b1;
                state_d = S_FEED;
            end
            S_FEED: begin
                in_ready = 1'b1;
                mac_en   = in_valid;
                if (in_valid) begin
                    beat_d = beat_inc;
                    // beat_inc never exceeds klen_q, so the counter cannot wrap.
                    if (beat_inc == klen_q) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // Dropping cnt_en on the done cycle leaves the counter at 0.
                cnt_en = !cnt_done;
                mac_en = !cnt_done;
                if (cnt_done) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (row_q == LAST_ROW) begin
                        row_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
